// File: rtl/tcdm_responder_package.sv
// Shared constants and response record for the TCDM responder.
package tcdm_responder_package;

  localparam logic [31:0] OOB_RDATA = 32'hDEADBEEF;

  typedef struct packed {
    logic        valid;
    logic [7:0]  port;
    logic [31:0] rdata;
    logic        oob;
  } resp_t;

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// TCDM request/response bundle shared between an accelerator master and a memory slave.
interface hwpe_stream_intf_tcdm;
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  logic        r_valid;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_q, then moves rr_q past it.
module tcdm_rr_arbiter #(
  parameter int unsigned NB_PORTS = 3,
  parameter int unsigned IDX_W    = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [NB_PORTS-1:0] req_i,
  output logic [NB_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]    idx_o,
  output logic                valid_o
);

  logic [IDX_W-1:0] rr_q, rr_d;

  always_comb begin
    int unsigned cand;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < NB_PORTS; k++) begin
      cand = (32'(rr_q) + k) % NB_PORTS;
      if (en_i && !valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = IDX_W'(cand);
        gnt_o[cand] = 1'b1;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (valid_o) begin
      rr_d = (32'(idx_o) == NB_PORTS - 1) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/tcdm_responder.sv
// Single-ported word memory serving several TCDM slave ports, one grant per cycle,
// with a one-cycle response and out-of-range detection.
module tcdm_responder
  import tcdm_responder_package::*;
#(
  parameter int unsigned NB_PORTS   = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 stall_i,
  hwpe_stream_intf_tcdm.slave  tcdm_slave [NB_PORTS-1:0],
  output logic                 oob_err_o,
  output logic [15:0]          oob_cnt_o
);

  localparam int unsigned ADDR_W = $clog2(MEM_WORDS);
  localparam int unsigned IDX_W  = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;

  logic [NB_PORTS-1:0]   req, gnt;
  logic [31:0]           add   [NB_PORTS];
  logic [NB_PORTS-1:0]   wen;
  logic [3:0]            be    [NB_PORTS];
  logic [DATA_WIDTH-1:0] wdata [NB_PORTS];

  resp_t                 resp_q, resp_d;
  logic [DATA_WIDTH-1:0] last_q [NB_PORTS];
  logic [15:0]           oob_cnt_q, oob_cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  for (genvar i = 0; i < NB_PORTS; i++) begin : g_port
    assign req[i]               = tcdm_slave[i].req;
    assign add[i]               = tcdm_slave[i].add;
    assign wen[i]               = tcdm_slave[i].wen;
    assign be[i]                = tcdm_slave[i].be;
    assign wdata[i]             = tcdm_slave[i].data;
    assign tcdm_slave[i].gnt    = gnt[i];
    assign tcdm_slave[i].r_valid = resp_q.valid && (resp_q.port == 8'(i));
    // Outside a response the port keeps showing the last data it was given.
    assign tcdm_slave[i].r_data = (resp_q.valid && (resp_q.port == 8'(i))) ? resp_q.rdata
                                                                             : last_q[i];
  end

  logic [IDX_W-1:0] win_idx;
  logic             win_valid;

  tcdm_rr_arbiter #(
    .NB_PORTS (NB_PORTS),
    .IDX_W    (IDX_W)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (~stall_i),
    .req_i   (req),
    .gnt_o   (gnt),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  logic [31:0]           sel_add;
  logic                  sel_wen;
  logic [3:0]            sel_be;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [ADDR_W-1:0]     mem_idx;
  logic                  sel_oob;
  logic [1:0]            unused_add_lsb;

  assign sel_add        = add[win_idx];
  assign sel_wen        = wen[win_idx];
  assign sel_be         = be[win_idx];
  assign sel_wdata      = wdata[win_idx];
  assign mem_idx        = sel_add[ADDR_W+1:2];
  assign sel_oob        = |(sel_add >> (ADDR_W + 2));
  assign unused_add_lsb = sel_add[1:0];

  always_comb begin
    resp_d = '0;
    if (win_valid) begin
      resp_d.valid = 1'b1;
      resp_d.port  = 8'(win_idx);
      resp_d.oob   = sel_oob;
      if (sel_wen) begin
        resp_d.rdata = sel_oob ? OOB_RDATA : mem_q[mem_idx];
      end
    end
  end

  always_comb begin
    oob_cnt_d = oob_cnt_q;
    if (win_valid && sel_oob && (oob_cnt_q != 16'hFFFF)) begin
      oob_cnt_d = oob_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_q    <= '0;
      oob_cnt_q <= '0;
      for (int i = 0; i < NB_PORTS; i++) begin
        last_q[i] <= '0;
      end
    end else begin
      resp_q    <= resp_d;
      oob_cnt_q <= oob_cnt_d;
      for (int i = 0; i < NB_PORTS; i++) begin
        if (resp_q.valid && (resp_q.port == 8'(i))) begin
          last_q[i] <= resp_q.rdata;
        end
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (win_valid && !sel_wen && !sel_oob) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_be[b]) begin
          mem_q[mem_idx][8*b +: 8] <= sel_wdata[8*b +: 8];
        end
      end
    end
  end

  assign oob_err_o = resp_q.valid & resp_q.oob;
  assign oob_cnt_o = oob_cnt_q;

endmodule

// File: tb/tb_tcdm_responder.sv
// Directed bench for tcdm_responder: access, byte enables, arbitration, stall, OOB, reset.
module tb_tcdm_responder;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        stall;
  logic        oob_err;
  logic [15:0] oob_cnt;

  logic [2:0]  req_v;
  logic [2:0]  wen_v;
  logic [31:0] add_v   [3];
  logic [3:0]  be_v    [3];
  logic [31:0] data_v  [3];
  logic [2:0]  gnt_v;
  logic [2:0]  rvalid_v;
  logic [31:0] rdata_v [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hwpe_stream_intf_tcdm tcdm [2:0] ();

  for (genvar i = 0; i < 3; i++) begin : g_if
    assign tcdm[i].req  = req_v[i];
    assign tcdm[i].wen  = wen_v[i];
    assign tcdm[i].add  = add_v[i];
    assign tcdm[i].be   = be_v[i];
    assign tcdm[i].data = data_v[i];
    assign gnt_v[i]     = tcdm[i].gnt;
    assign rvalid_v[i]  = tcdm[i].r_valid;
    assign rdata_v[i]   = tcdm[i].r_data;
  end

  tcdm_responder #(
    .NB_PORTS   (3),
    .DATA_WIDTH (32),
    .MEM_WORDS  (1024)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .stall_i    (stall),
    .tcdm_slave (tcdm),
    .oob_err_o  (oob_err),
    .oob_cnt_o  (oob_cnt)
  );

  // One single-port request; returns grant seen before the edge and response after it.
  task automatic do_access(input int p, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b,
                           output logic [2:0] g, output logic [2:0] rv,
                           output logic [31:0] rd, output logic oe);
    @(negedge clk);
    req_v[p] = 1'b1; wen_v[p] = w; add_v[p] = a; data_v[p] = d; be_v[p] = b;
    #1 g = gnt_v;
    @(posedge clk);
    #1 rv = rvalid_v; rd = rdata_v[p]; oe = oob_err;
    req_v[p] = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (rvalid_v !== 3'b000) begin
      n_fail++; $display("FAIL reset_rvalid got %b exp 000", rvalid_v);
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (rdata_v[i] !== 32'h0) begin
        n_fail++; $display("FAIL reset_rdata%0d got %h exp 0", i, rdata_v[i]);
      end
    end
    n_tests++;
    if (oob_err !== 1'b0 || oob_cnt !== 16'h0) begin
      n_fail++; $display("FAIL reset_oob got err=%b cnt=%h exp 0/0", oob_err, oob_cnt);
    end
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_write_read();
    logic [2:0] g, rv; logic [31:0] rd; logic oe;
    do_access(0, 1'b0, 32'h10, 32'hA5A5A5A5, 4'hF, g, rv, rd, oe);
    n_tests++;
    if (g !== 3'b001) begin n_fail++; $display("FAIL wr_gnt got %b exp 001", g); end
    n_tests++;
    if (rv !== 3'b001 || rd !== 32'h0) begin
      n_fail++; $display("FAIL wr_resp got rv=%b rd=%h exp 001/0", rv, rd);
    end
    do_access(1, 1'b1, 32'h10, 32'h0, 4'hF, g, rv, rd, oe);
    n_tests++;
    if (g !== 3'b010) begin n_fail++; $display("FAIL rd_gnt got %b exp 010", g); end
    n_tests++;
    if (rv !== 3'b010 || rd !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL rd_resp got rv=%b rd=%h exp 010/a5a5a5a5", rv, rd);
    end
    @(posedge clk); #1;
    n_tests++;
    if (rvalid_v !== 3'b000 || rdata_v[1] !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL rd_hold got rv=%b rd=%h exp 000/a5a5a5a5", rvalid_v, rdata_v[1]);
    end
  endtask

  task automatic test_byte_enable();
    logic [2:0] g, rv; logic [31:0] rd; logic oe;
    do_access(0, 1'b0, 32'h20, 32'h11223344, 4'hF, g, rv, rd, oe);
    do_access(0, 1'b0, 32'h22, 32'hFFFFFFFF, 4'h2, g, rv, rd, oe);
    do_access(2, 1'b1, 32'h20, 32'h0, 4'hF, g, rv, rd, oe);
    n_tests++;
    if (rv !== 3'b100 || rd !== 32'h1122FF44) begin
      n_fail++; $display("FAIL be_merge got rv=%b rd=%h exp 100/1122ff44", rv, rd);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [6];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      wen_v[i] = 1'b1; add_v[i] = 32'h0; be_v[i] = 4'hF;
    end
    req_v = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_tests++;
      if (gnt_v !== exp_g[k]) begin
        n_fail++; $display("FAIL rr_gnt%0d got %b exp %b", k, gnt_v, exp_g[k]);
      end
      @(posedge clk); #1;
      n_tests++;
      if (rvalid_v !== exp_g[k]) begin
        n_fail++; $display("FAIL rr_rvalid%0d got %b exp %b", k, rvalid_v, exp_g[k]);
      end
      @(negedge clk);
    end
    req_v = 3'b000;
  endtask

  task automatic test_stall();
    @(negedge clk);
    stall = 1'b1;
    req_v[2] = 1'b1; wen_v[2] = 1'b1; add_v[2] = 32'h0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_tests++;
      if (gnt_v !== 3'b000) begin
        n_fail++; $display("FAIL stall_gnt%0d got %b exp 000", k, gnt_v);
      end
      @(posedge clk); #1;
      n_tests++;
      if (rvalid_v !== 3'b000) begin
        n_fail++; $display("FAIL stall_rvalid%0d got %b exp 000", k, rvalid_v);
      end
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    n_tests++;
    if (gnt_v !== 3'b100) begin
      n_fail++; $display("FAIL stall_release got %b exp 100", gnt_v);
    end
    @(posedge clk); #1;
    req_v[2] = 1'b0;
  endtask

  task automatic test_oob();
    logic [2:0] g, rv; logic [31:0] rd; logic oe;
    do_access(1, 1'b1, 32'h0001_0000, 32'h0, 4'hF, g, rv, rd, oe);
    n_tests++;
    if (rv !== 3'b010 || rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL oob_rd got rv=%b rd=%h exp 010/deadbeef", rv, rd);
    end
    n_tests++;
    if (oe !== 1'b1 || oob_cnt !== 16'd1) begin
      n_fail++; $display("FAIL oob_flag got err=%b cnt=%0d exp 1/1", oe, oob_cnt);
    end
    do_access(0, 1'b0, 32'h0001_0010, 32'h0, 4'hF, g, rv, rd, oe);
    n_tests++;
    if (rv !== 3'b001 || oe !== 1'b1 || oob_cnt !== 16'd2) begin
      n_fail++; $display("FAIL oob_wr got rv=%b err=%b cnt=%0d exp 001/1/2", rv, oe, oob_cnt);
    end
    do_access(2, 1'b1, 32'h10, 32'h0, 4'hF, g, rv, rd, oe);
    n_tests++;
    if (rd !== 32'hA5A5A5A5 || oe !== 1'b0) begin
      n_fail++; $display("FAIL oob_wr_dropped got rd=%h err=%b exp a5a5a5a5/0", rd, oe);
    end
  endtask

  task automatic test_reset_in_grant();
    logic [2:0] g, rv; logic [31:0] rd; logic oe;
    do_access(1, 1'b1, 32'h10, 32'h0, 4'hF, g, rv, rd, oe);
    n_tests++;
    if (rd !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL rg_pre got %h exp a5a5a5a5", rd);
    end
    @(negedge clk);
    req_v[1] = 1'b1; wen_v[1] = 1'b1; add_v[1] = 32'h10;
    #1;
    n_tests++;
    if (gnt_v !== 3'b010) begin n_fail++; $display("FAIL rg_gnt got %b exp 010", gnt_v); end
    #1 rst_ni = 1'b0;
    #1;
    n_tests++;
    if (rvalid_v !== 3'b000 || rdata_v[1] !== 32'h0 || oob_cnt !== 16'h0) begin
      n_fail++; $display("FAIL rg_async got rv=%b rd=%h cnt=%h exp 000/0/0",
                         rvalid_v, rdata_v[1], oob_cnt);
    end
    @(posedge clk);
    @(negedge clk);
    req_v = 3'b000;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (rvalid_v !== 3'b000) begin
      n_fail++; $display("FAIL rg_no_resp got %b exp 000", rvalid_v);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      wen_v[i] = 1'b1; add_v[i] = 32'h0;
    end
    req_v = 3'b111;
    #1;
    n_tests++;
    if (gnt_v !== 3'b001) begin
      n_fail++; $display("FAIL rg_first_winner got %b exp 001", gnt_v);
    end
    @(posedge clk); #1;
    req_v = 3'b000;
  endtask

  initial begin
    rst_ni = 1'b0;
    stall  = 1'b0;
    req_v  = 3'b000;
    wen_v  = 3'b111;
    for (int i = 0; i < 3; i++) begin
      add_v[i] = 32'h0; be_v[i] = 4'h0; data_v[i] = 32'h0;
    end
    test_reset();
    test_write_read();
    test_byte_enable();
    test_round_robin();
    test_stall();
    test_oob();
    test_reset_in_grant();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule

// File: doc/tcdm_responder.md
TCDM_RESPONDER -- requirements
Module: tcdm_responder

Interface
REQ-001 SHALL have parameter NB_PORTS, default 3, number of TCDM slave ports (matches NB_OPERANDS+NB_RESULTS of the accelerator top).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width; only 32 is supported.
REQ-003 SHALL have parameter MEM_WORDS, default 1024, storage depth in words; must be a power of two.
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit, reset; asynchronous, active-low.
REQ-006 SHALL have port stall_i, input, 1 bit; when 1, no grant is issued that cycle.
REQ-007 SHALL have port tcdm_slave[NB_PORTS-1:0], hwpe_stream_intf_tcdm.slave: req/add/wen/be/data in; gnt/r_data/r_valid out.
REQ-008 SHALL have port oob_err_o, output, 1 bit; pulses for one cycle with the response to an out-of-range access.
REQ-009 SHALL have port oob_cnt_o, output, 16 bits; count of out-of-range accesses.

Function
REQ-010 SHALL model one single-ported word memory of MEM_WORDS x 32 bits, shared by all ports.
REQ-011 SHALL grant at most one request per cycle: gnt combinational, same cycle as req, driven to one port only.
REQ-012 SHALL arbitrate round-robin: the winner is the lowest port index >= rr_q with req=1, wrapping to 0; after a grant, rr_q <= (winner+1) mod NB_PORTS; rr_q holds when nothing is granted.
REQ-013 SHALL issue no grant when stall_i=1 or no req is asserted; rr_q unchanged.
REQ-014 SHALL decode the word index as add[log2(MEM_WORDS)+1:2]; add[1:0] ignored.
REQ-015 SHALL flag as out-of-range any access with nonzero add bits above log2(MEM_WORDS)+1.
REQ-016 SHALL treat wen=0 as a write and wen=1 as a read.
REQ-017 SHALL on a granted in-range write update only the bytes with be[i]=1; other bytes unchanged.
REQ-018 SHALL assert r_valid on the granted port exactly one cycle after the grant, for reads and writes; r_valid=0 on all other ports.
REQ-019 SHALL drive r_data = memory word before any same-cycle write for a granted in-range read; r_data = 0 for writes; r_data = 32'hDEADBEEF for an out-of-range read.
REQ-020 SHALL drop out-of-range writes (memory untouched), still returning r_valid.
REQ-021 SHALL make a write granted in cycle t visible to reads granted in cycle t+1 or later.
REQ-022 SHALL hold r_data at its last value when r_valid=0.
REQ-023 SHALL pulse oob_err_o aligned with r_valid of the out-of-range response.
REQ-024 SHALL increment oob_cnt_o on each out-of-range grant, saturating at 16'hFFFF.
REQ-025 SHALL allow back-to-back grants every cycle, so a port holding req continuously is granted whenever it wins arbitration.

Reset
REQ-026 SHALL on rst_ni=0 immediately set rr_q=0, all r_valid=0, all r_data=0, oob_err_o=0 and oob_cnt_o=0.
REQ-027 SHALL drop the pending response of a grant issued in the cycle reset asserts; no r_valid after release.
REQ-028 SHALL leave memory contents unreset (undefined until written).

Structure
REQ-029 SHALL place the OOB_RDATA constant (32'hDEADBEEF) and a response typedef (valid, port index, rdata, oob) in package tcdm_responder_package.
REQ-030 SHALL implement arbitration in a sub-module tcdm_rr_arbiter (req vector in, one-hot grant and winner index out, rr pointer registered inside).

Verification
REQ-031 SHALL cover: port0 write add=0x10, data=0xA5A5A5A5, be=0xF; then port1 read add=0x10 -> r_valid on port1 one cycle after gnt, r_data=0xA5A5A5A5.
REQ-032 SHALL cover: write 0x11223344 then be=0x2 write 0xFFFFFFFF to the same address; read -> 0x1122FF44.
REQ-033 SHALL cover: all 3 ports hold req from reset -> grants in order 0,1,2,0,1,2, exactly one per cycle.
REQ-034 SHALL cover: stall_i=1 for 4 cycles with port2 requesting -> gnt=0 for 4 cycles, port2 granted the cycle stall_i falls.
REQ-035 SHALL cover: read add=0x0001_0000 with MEM_WORDS=1024 -> r_data=0xDEADBEEF, oob_err_o pulse, oob_cnt_o=1; an out-of-range write leaves memory unchanged.
REQ-036 SHALL cover: rst_ni asserted in the grant cycle of a read -> no r_valid, rr_q=0, port0 wins first after release.
